cmp_stream_minmax: RTL and testbench
====================================

Name: cmp_stream_minmax

Overview:
Streaming magnitude comparator with a valid/ready handshake on both sides and one registered output stage.
- Each accepted (a, b) pair produces registered lt/gt/eq flags; signed or unsigned interpretation is selected per sample.
- Also tracks the running minimum and maximum of accepted a samples and counts equal results.
- Sits between a sample source and downstream threshold/decision logic as the clocked, parametrised successor to the team's combinational comparator.

Parameters:
WIDTH, 16, operand width in bits (>=2)
CNT_W, 16, width of eq_count (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  block can accept a pair this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
signed_mode  in  1  1: two's-complement compare; 0: unsigned; sampled with the pair
clr  in  1  synchronous clear of min/max tracker and eq_count
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
lt  out  1  a < b for the held result
gt  out  1  a > b for the held result
eq  out  1  a == b for the held result
min_val  out  WIDTH  minimum accepted a since reset/clr
max_val  out  WIDTH  maximum accepted a since reset/clr
minmax_valid  out  1  min_val/max_val hold at least one sample
eq_count  out  CNT_W  number of accepted pairs with a == b, saturating

Behaviour:
- Reset is sampled on a clk edge with rst_n=0. Reset values: out_valid=0, lt=gt=eq=0, min_val=0, max_val=0, minmax_valid=0, eq_count=0. in_ready becomes 1 in the cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle. A pair accepted at edge N is presented with out_valid=1 after edge N. The result stays stable until it is transferred.
- Back-to-back: with out_ready held at 1, one pair is accepted per cycle (full throughput).
- out_valid:
  - Set on accept.
  - Cleared on transfer with no simultaneous accept.
  - Stays 1 on simultaneous transfer and accept; the new result replaces the old one.
- Flags: exactly one of lt/gt/eq is 1 whenever out_valid=1.
  - signed_mode=1: both operands are compared as two's complement.
  - signed_mode=0: both operands are compared as unsigned.
  - The mode is per sample and registered with the pair.
- Min/max tracker, two states:
  - EMPTY (minmax_valid=0): on accept, min_val = max_val = a, then go to TRACK.
  - TRACK: on accept, update min_val if a < min_val and max_val if a > max_val.
  - Tracker comparisons use the accepted sample's signed_mode. Mixing modes between samples is legal; each update uses the current sample's mode.
  - Tracker outputs update on the same edge as the result flags.
- eq_count: increments by 1 on each accept whose pair is equal. It saturates at 2^CNT_W-1 and never wraps.
- clr (evaluated on the edge):
  - clr=1 with no accept: tracker goes to EMPTY, min_val=max_val=0, eq_count=0.
  - clr=1 together with an accept: the clear applies first, then the accepted sample. Tracker goes to TRACK with min=max=a; eq_count = 1 if the pair is equal, else 0.
  - clr does not affect out_valid or lt/gt/eq.
- Reset mid-operation:
  - Any held result is discarded; out_valid=0 after the reset edge.
  - A pair presented during reset is not accepted.
  - Reset has priority over clr and accept.
- Inputs are ignored when in_ready=0. The source must hold the pair stable until it is accepted.

Test Plan:
- Unsigned compare, WIDTH=16, signed_mode=0, out_ready=1: (a,b) = (0x8000,0x0001) -> gt=1; (0x0001,0x8000) -> lt=1; (0x1234,0x1234) -> eq=1, eq_count=1. Each result appears one cycle after its accept.
- Signed compare, signed_mode=1: (0x8000,0x0001) -> lt=1; (0xFFFF,0x0000) -> lt=1; (0x7FFF,0x8000) -> gt=1.
- Backpressure: out_ready=0, send 3 pairs -> only the first is accepted, in_ready=0, the result is held stable. Raise out_ready -> the remaining pairs are accepted one per cycle, in order, with none lost or duplicated.
- Min/max tracking: after reset, unsigned a samples 5,200,3,0xFFFF -> min_val=3, max_val=0xFFFF, minmax_valid=1. Then clr with no accept -> minmax_valid=0, min_val=max_val=0, eq_count=0.
- Clear plus accept: clr=1 with an accepted equal pair a=b=7 -> min=max=7, minmax_valid=1, eq_count=1.
- Saturation and reset: CNT_W=2, five equal pairs -> eq_count sticks at 3. Assert rst_n=0 while out_valid=1 -> every output returns to its reset value on that edge.

Source files
------------

// File: rtl/cmp_stream_minmax.sv
// Streaming signed/unsigned magnitude comparator with a one-stage registered
// valid/ready output, a running min/max tracker on operand a, and a saturating eq counter.
module cmp_stream_minmax #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
    output logic             minmax_valid,
    output logic [CNT_W-1:0] eq_count
);

    localparam logic [0:0]       ST_EMPTY = 1'b0;
    localparam logic [0:0]       ST_TRACK = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0]       state;
    logic             accept;
    logic [WIDTH-1:0] a_key, b_key, min_key, max_key;
    logic             a_lt_b, a_gt_b, a_eq_b;
    logic             a_lt_min, a_gt_max;

    // Flipping the MSB in signed mode maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v, input logic s);
        return {v[WIDTH-1] ^ s, v[WIDTH-2:0]};
    endfunction

    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign minmax_valid = (state == ST_TRACK);

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_key    = order_key(a, signed_mode);
        b_key    = order_key(b, signed_mode);
        min_key  = order_key(min_val, signed_mode);
        max_key  = order_key(max_val, signed_mode);
        a_lt_b   = a_key < b_key;
        a_gt_b   = a_key > b_key;
        a_eq_b   = (a == b);
        a_lt_min = a_key < min_key;
        a_gt_max = a_key > max_key;
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            state     <= ST_EMPTY;
            min_val   <= '0;
            max_val   <= '0;
            eq_count  <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                lt        <= a_lt_b;
                gt        <= a_gt_b;
                eq        <= a_eq_b;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // clr is applied before a same-cycle sample, so that sample seeds the tracker.
            if (accept && (clr || state == ST_EMPTY)) begin
                min_val <= a;
                max_val <= a;
                state   <= ST_TRACK;
            end else if (clr) begin
                min_val <= '0;
                max_val <= '0;
                state   <= ST_EMPTY;
            end else if (accept) begin
                if (a_lt_min) min_val <= a;
                if (a_gt_max) max_val <= a;
            end

            if (clr) begin
                eq_count <= (accept && a_eq_b) ? CNT_W'(1) : '0;
            end else if (accept && a_eq_b && eq_count != CNT_MAX) begin
                eq_count <= eq_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp_stream_minmax.sv
// Scoreboard bench for cmp_stream_minmax: directed pairs push hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_cmp_stream_minmax;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        signed_mode;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic        lt, gt, eq;
    logic [15:0] min_val, max_val;
    logic        minmax_valid;
    logic [1:0]  eq_count;

    typedef struct packed {
        logic [2:0]  flags;   // {lt, gt, eq}
        logic [15:0] mn;
        logic [15:0] mx;
        logic        mmv;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    cmp_stream_minmax #(.WIDTH(16), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .signed_mode  (signed_mode),
        .clr          (clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .lt           (lt),
        .gt           (gt),
        .eq           (eq),
        .min_val      (min_val),
        .max_val      (max_val),
        .minmax_valid (minmax_valid),
        .eq_count     (eq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the posedge following a negedge with out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got flags %b with no result expected", {lt, gt, eq});
            end else begin
                mon_e = exp_q.pop_front();
                check("flags",        {lt, gt, eq},  mon_e.flags);
                check("min_val",      min_val,       mon_e.mn);
                check("max_val",      max_val,       mon_e.mx);
                check("minmax_valid", minmax_valid,  mon_e.mmv);
                check("eq_count",     eq_count,      mon_e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        clr      = 1'b0;
        repeat (n) tick();
    endtask

    // Presents a pair until accepted; the expected result is queued at the accepting edge.
    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vm,
                        input logic vc, input logic [2:0] ef, input logic [15:0] emn,
                        input logic [15:0] emx, input logic [1:0] ecnt);
        bit got;
        got         = 1'b0;
        a           = va;
        b           = vb;
        signed_mode = vm;
        clr         = vc;
        in_valid    = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back({ef, emn, emx, 1'b1, ecnt});
                got = 1'b1;
            end
            tick();
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: pair a=0x%0h b=0x%0h not accepted within 50 cycles", va, vb);
        end
    endtask

    task automatic lat_check();
        in_valid = 1'b0;
        clr      = 1'b0;
        @(negedge clk);
        check("latency_out_valid", out_valid, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        signed_mode = 1'b0; clr = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_outputs",
              {out_valid, lt, gt, eq, min_val, max_val, minmax_valid, eq_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);
        tick();
        out_ready = 1'b1;

        // Unsigned compares, one at a time
        send(16'h8000, 16'h0001, 1'b0, 1'b0, 3'b010, 16'h8000, 16'h8000, 2'd0); lat_check();
        send(16'h0001, 16'h8000, 1'b0, 1'b0, 3'b100, 16'h0001, 16'h8000, 2'd0); lat_check();
        send(16'h1234, 16'h1234, 1'b0, 1'b0, 3'b001, 16'h0001, 16'h8000, 2'd1); lat_check();

        // Signed compares back to back; first one also clears the tracker
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 3'b100, 16'h8000, 16'h8000, 2'd0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 3'b100, 16'h8000, 16'hFFFF, 2'd0);
        send(16'h7FFF, 16'h8000, 1'b1, 1'b0, 3'b010, 16'h8000, 16'h7FFF, 2'd0);
        idle(2);

        // Backpressure: first pair accepted, second stalls while the result is held
        out_ready = 1'b0;
        send(16'h0010, 16'h0020, 1'b0, 1'b0, 3'b100, 16'h0010, 16'h7FFF, 2'd0);
        a = 16'h0030; b = 16'h0030; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_held", {out_valid, lt, gt, eq}, 4'b1100);
            tick();
        end
        out_ready = 1'b1;
        send(16'h0030, 16'h0030, 1'b0, 1'b0, 3'b001, 16'h0010, 16'h7FFF, 2'd1);
        send(16'h9000, 16'h0001, 1'b0, 1'b0, 3'b010, 16'h0010, 16'h9000, 2'd1);
        idle(3);

        // Min/max tracking from a freshly cleared tracker, then clear with no accept
        send(16'h0005, 16'h0000, 1'b0, 1'b1, 3'b010, 16'h0005, 16'h0005, 2'd0);
        send(16'd200,  16'h0000, 1'b0, 1'b0, 3'b010, 16'h0005, 16'd200,  2'd0);
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 3'b100, 16'h0003, 16'd200,  2'd0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 3'b001, 16'h0003, 16'hFFFF, 2'd1);
        idle(3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_no_accept", {minmax_valid, min_val, max_val, eq_count}, 64'd0);
        tick();

        // Clear plus equal accept, then saturation of the 2-bit counter
        send(16'h0007, 16'h0007, 1'b0, 1'b1, 3'b001, 16'h0007, 16'h0007, 2'd1);
        send(16'h0007, 16'h0007, 1'b0, 1'b0, 3'b001, 16'h0007, 16'h0007, 2'd2);
        send(16'h0007, 16'h0007, 1'b0, 1'b0, 3'b001, 16'h0007, 16'h0007, 2'd3);
        send(16'h0007, 16'h0007, 1'b0, 1'b0, 3'b001, 16'h0007, 16'h0007, 2'd3);
        send(16'h0007, 16'h0007, 1'b0, 1'b0, 3'b001, 16'h0007, 16'h0007, 2'd3);
        idle(2);

        // Reset while a result is held; a pair presented during reset must be dropped
        out_ready = 1'b0;
        send(16'h0009, 16'h0002, 1'b0, 1'b0, 3'b010, 16'h0007, 16'h0009, 2'd3);
        a = 16'h0004; b = 16'h0005; in_valid = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        check("held_before_reset", {out_valid, lt, gt, eq, max_val, eq_count},
              {1'b1, 3'b010, 16'h0009, 2'd3});
        tick();
        exp_q.delete();
        @(negedge clk);
        check("reset_mid_outputs",
              {out_valid, lt, gt, eq, min_val, max_val, minmax_valid, eq_count}, 64'd0);
        tick();
        @(negedge clk);
        check("reset_blocks_accept", {out_valid, minmax_valid}, 2'b00);
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {in_ready, out_valid}, 2'b10);
        tick();
        send(16'h0002, 16'h0003, 1'b0, 1'b0, 3'b100, 16'h0002, 16'h0002, 2'd0);
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
